// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer for the OV5640 SCCB bit-shift engine: turns one
// register write/read request into the ordered byte commands (Cmd/Go/Trans_Done).
module i2c_reg_ctrl #(
  parameter bit ADDR_16BIT = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_p,
  input  logic        wrreg_req,
  input  logic        rdreg_req,
  input  logic [6:0]  dev_id,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        rw_done,
  output logic        ack_err,
  output logic        busy,
  output logic [5:0]  Cmd,
  output logic        Go,
  output logic [7:0]  Tx_DATA,
  input  logic [7:0]  Rx_DATA,
  input  logic        Trans_Done,
  input  logic        ack_o
);

  localparam logic [5:0] CMD_WR   = 6'b000001;
  localparam logic [5:0] CMD_STA  = 6'b000010;
  localparam logic [5:0] CMD_RD   = 6'b000100;
  localparam logic [5:0] CMD_STO  = 6'b001000;
  localparam logic [5:0] CMD_NACK = 6'b100000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        is_rd_q, is_rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  logic        settle_q, settle_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ack_err_q, ack_err_d;

  logic [2:0]  step;
  logic [5:0]  byte_cmd;
  logic [7:0]  byte_tx;
  logic        last_byte;
  logic        err_next;

  // Byte index maps onto the 16-bit-address step list; the high address byte
  // is skipped when only an 8-bit register address is used.
  always_comb begin
    step = idx_q;
    if (!ADDR_16BIT && idx_q != 3'd0) begin
      step = idx_q + 3'd1;
    end
    byte_cmd = CMD_RD | CMD_NACK | CMD_STO;
    byte_tx  = 8'h00;
    case (step)
      3'd0: begin
        byte_cmd = CMD_STA | CMD_WR;
        byte_tx  = {dev_q, 1'b0};
      end
      3'd1: begin
        byte_cmd = CMD_WR;
        byte_tx  = addr_q[15:8];
      end
      3'd2: begin
        byte_cmd = is_rd_q ? (CMD_WR | CMD_STO) : CMD_WR;
        byte_tx  = addr_q[7:0];
      end
      3'd3: begin
        byte_cmd = is_rd_q ? (CMD_STA | CMD_WR) : (CMD_WR | CMD_STO);
        byte_tx  = is_rd_q ? {dev_q, 1'b1} : data_q;
      end
      default: begin
        byte_cmd = CMD_RD | CMD_NACK | CMD_STO;
        byte_tx  = 8'h00;
      end
    endcase
    last_byte = is_rd_q ? (step == 3'd4) : (step == 3'd3);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    is_rd_d   = is_rd_q;
    dev_d     = dev_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    settle_d  = settle_q;
    rd_data_d = rd_data_q;
    ack_err_d = ack_err_q;
    err_next  = err_q | (byte_cmd[0] & ack_o);
    Cmd       = 6'b000000;
    Tx_DATA   = 8'h00;
    Go        = 1'b0;
    rw_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrreg_req || rdreg_req) begin
          is_rd_d  = !wrreg_req;
          dev_d    = dev_id;
          addr_d   = reg_addr;
          data_d   = wr_data;
          idx_d    = 3'd0;
          err_d    = 1'b0;
          settle_d = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        Cmd     = byte_cmd;
        Tx_DATA = byte_tx;
        // After a completed byte the new Cmd/Tx_DATA get one settle cycle before Go.
        if (settle_q) begin
          settle_d = 1'b0;
        end else begin
          Go      = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        Cmd     = byte_cmd;
        Tx_DATA = byte_tx;
        if (Trans_Done) begin
          err_d = err_next;
          if (last_byte) begin
            ack_err_d = err_next;
            if (is_rd_q) begin
              rd_data_d = Rx_DATA;
            end
            state_d = DONE;
          end else begin
            idx_d    = idx_q + 3'd1;
            settle_d = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      DONE: begin
        rw_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      is_rd_q   <= 1'b0;
      dev_q     <= 7'd0;
      addr_q    <= 16'd0;
      data_q    <= 8'd0;
      err_q     <= 1'b0;
      settle_q  <= 1'b0;
      rd_data_q <= 8'd0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      is_rd_q   <= is_rd_d;
      dev_q     <= dev_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      settle_q  <= settle_d;
      rd_data_q <= rd_data_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign rd_data = rd_data_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed, table-driven bench for i2c_reg_ctrl with a simple byte-engine model
// driving Trans_Done/ack_o/Rx_DATA; covers 16-bit and 8-bit address builds.
module tb_i2c_reg_ctrl;

  logic        Clk = 1'b0;
  always #10 Clk = ~Clk;

  logic        Rst_p;
  logic        wr16, rd16, wr8, rd8;
  logic [6:0]  dev_id;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data;
  logic [7:0]  Rx_DATA;
  logic        Trans_Done, ack_o;

  logic [7:0] rd_data16, rd_data8, tx16, tx8;
  logic       rw_done16, rw_done8, ack_err16, ack_err8, busy16, busy8, go16, go8;
  logic [5:0] cmd16, cmd8;

  i2c_reg_ctrl #(.ADDR_16BIT(1'b1)) dut16 (
    .Clk(Clk), .Rst_p(Rst_p), .wrreg_req(wr16), .rdreg_req(rd16),
    .dev_id(dev_id), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data16), .rw_done(rw_done16), .ack_err(ack_err16), .busy(busy16),
    .Cmd(cmd16), .Go(go16), .Tx_DATA(tx16),
    .Rx_DATA(Rx_DATA), .Trans_Done(Trans_Done), .ack_o(ack_o)
  );

  i2c_reg_ctrl #(.ADDR_16BIT(1'b0)) dut8 (
    .Clk(Clk), .Rst_p(Rst_p), .wrreg_req(wr8), .rdreg_req(rd8),
    .dev_id(dev_id), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data8), .rw_done(rw_done8), .ack_err(ack_err8), .busy(busy8),
    .Cmd(cmd8), .Go(go8), .Tx_DATA(tx8),
    .Rx_DATA(Rx_DATA), .Trans_Done(Trans_Done), .ack_o(ack_o)
  );

  logic       sel8;
  logic [7:0] rd_data_s, tx_s;
  logic       rw_done_s, ack_err_s, busy_s, go_s;
  logic [5:0] cmd_s;
  always_comb begin
    rd_data_s = sel8 ? rd_data8  : rd_data16;
    tx_s      = sel8 ? tx8       : tx16;
    rw_done_s = sel8 ? rw_done8  : rw_done16;
    ack_err_s = sel8 ? ack_err8  : ack_err16;
    busy_s    = sel8 ? busy8     : busy16;
    go_s      = sel8 ? go8       : go16;
    cmd_s     = sel8 ? cmd8      : cmd16;
  end

  typedef struct {
    bit          use8;
    bit          wr;
    bit          rd;
    logic [6:0]  dev;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rx;
    int          nack_idx;
    bit          poke;
    int          nb;
    logic [39:0] tx;
    logic [29:0] cmd;
    bit          err;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_rd [2];
  bit   early_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_go(output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
      if (rw_done_s && !go_s) early_done = 1'b1;
    end while (!go_s && cyc < 20);
  endtask

  task automatic set_req(input bit use8, input bit w, input bit r);
    if (use8) begin wr8 = w; rd8 = r; end
    else begin wr16 = w; rd16 = r; end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   cyc;
    bit   go_seen;
    logic [5:0] ec;
    logic [7:0] et;
    sel8       = v.use8;
    early_done = 1'b0;
    dev_id     = v.dev;
    reg_addr   = v.addr;
    wr_data    = v.wd;
    set_req(v.use8, v.wr, v.rd);
    for (int b = 0; b < v.nb; b++) begin
      ec = v.cmd[29-6*b -: 6];
      et = v.tx[39-8*b -: 8];
      wait_go(cyc);
      check($sformatf("v%0d b%0d go_latency", id, b), cyc, 1);
      check($sformatf("v%0d b%0d cmd", id, b), cmd_s, ec);
      if (!ec[2]) check($sformatf("v%0d b%0d tx", id, b), tx_s, et);
      if (b == 0) begin
        set_req(v.use8, 1'b0, 1'b0);
        check($sformatf("v%0d busy_accept", id), busy_s, 1);
      end
      if (v.poke && b == 1) set_req(v.use8, 1'b0, 1'b1);
      go_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge Clk);
        if (k == 0) set_req(v.use8, 1'b0, 1'b0);
        if (go_s) go_seen = 1'b1;
        if (rw_done_s) early_done = 1'b1;
      end
      check($sformatf("v%0d b%0d single_go", id, b), go_seen, 0);
      check($sformatf("v%0d b%0d cmd_hold", id, b), cmd_s, ec);
      Trans_Done = 1'b1;
      ack_o      = (b == v.nack_idx);
      Rx_DATA    = ec[2] ? v.rx : 8'hEE;
      @(negedge Clk);
      Trans_Done = 1'b0;
      ack_o      = 1'b0;
      Rx_DATA    = 8'h00;
      if (b < v.nb - 1) begin
        check($sformatf("v%0d b%0d settle_no_go", id, b), go_s, 0);
        check($sformatf("v%0d b%0d no_early_done", id, b), rw_done_s, 0);
      end
    end
    if (v.rd && !v.wr) last_rd[v.use8] = v.rx;
    check($sformatf("v%0d rw_done", id), rw_done_s, 1);
    check($sformatf("v%0d ack_err", id), ack_err_s, v.err);
    check($sformatf("v%0d rd_data", id), rd_data_s, last_rd[v.use8]);
    check($sformatf("v%0d busy_at_done", id), busy_s, 1);
    check($sformatf("v%0d early_done", id), early_done, 0);
    $display("[TB] txn %0d: %s addr=%h done ack_err=%0b rd_data=%h", id,
             (v.rd && !v.wr) ? "read" : "write", v.addr, ack_err_s, rd_data_s);
    @(negedge Clk);
    check($sformatf("v%0d rw_done_pulse", id), rw_done_s, 0);
    check($sformatf("v%0d idle_busy", id), busy_s, 0);
    check($sformatf("v%0d idle_cmd", id), cmd_s, 0);
    check($sformatf("v%0d ack_err_hold", id), ack_err_s, v.err);
    go_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (go_s || busy_s) go_seen = 1'b1;
    end
    check($sformatf("v%0d no_extra_txn", id), go_seen, 0);
  endtask

  function automatic vec_t mk(bit u8, bit w, bit r, logic [6:0] dev, logic [15:0] a,
                              logic [7:0] wd, logic [7:0] rx, int nack, bit poke, int nb,
                              logic [39:0] tx, logic [29:0] cmd, bit err);
    vec_t v;
    v.use8 = u8; v.wr = w; v.rd = r; v.dev = dev; v.addr = a; v.wd = wd; v.rx = rx;
    v.nack_idx = nack; v.poke = poke; v.nb = nb; v.tx = tx; v.cmd = cmd; v.err = err;
    return v;
  endfunction

  vec_t vecs [8];

  initial begin
    int   cyc;
    bit   seen;
    vecs[0] = mk(0, 1, 0, 7'h3C, 16'h3008, 8'h82, 8'h00, -1, 0, 4,
                 {8'h78, 8'h30, 8'h08, 8'h82, 8'h00},
                 {6'b000011, 6'b000001, 6'b000001, 6'b001001, 6'b000000}, 0);
    vecs[1] = mk(0, 0, 1, 7'h3C, 16'h300A, 8'h00, 8'h56, -1, 0, 5,
                 {8'h78, 8'h30, 8'h0A, 8'h79, 8'h00},
                 {6'b000011, 6'b000001, 6'b001001, 6'b000011, 6'b101100}, 0);
    vecs[2] = mk(0, 1, 0, 7'h3C, 16'h4740, 8'hA5, 8'h00, 1, 0, 4,
                 {8'h78, 8'h47, 8'h40, 8'hA5, 8'h00},
                 {6'b000011, 6'b000001, 6'b000001, 6'b001001, 6'b000000}, 1);
    vecs[3] = mk(0, 1, 0, 7'h3C, 16'h5001, 8'h0F, 8'h00, -1, 0, 4,
                 {8'h78, 8'h50, 8'h01, 8'h0F, 8'h00},
                 {6'b000011, 6'b000001, 6'b000001, 6'b001001, 6'b000000}, 0);
    vecs[4] = mk(0, 1, 1, 7'h3C, 16'h3820, 8'h41, 8'h00, -1, 1, 4,
                 {8'h78, 8'h38, 8'h20, 8'h41, 8'h00},
                 {6'b000011, 6'b000001, 6'b000001, 6'b001001, 6'b000000}, 0);
    vecs[5] = mk(1, 1, 0, 7'h3C, 16'h0012, 8'h80, 8'h00, -1, 0, 3,
                 {8'h78, 8'h12, 8'h80, 8'h00, 8'h00},
                 {6'b000011, 6'b000001, 6'b001001, 6'b000000, 6'b000000}, 0);
    vecs[6] = mk(1, 0, 1, 7'h21, 16'h0034, 8'h00, 8'h9C, -1, 0, 4,
                 {8'h42, 8'h34, 8'h43, 8'h00, 8'h00},
                 {6'b000011, 6'b001001, 6'b000011, 6'b101100, 6'b000000}, 0);
    vecs[7] = mk(0, 1, 0, 7'h3C, 16'h3103, 8'h02, 8'h00, -1, 0, 4,
                 {8'h78, 8'h31, 8'h03, 8'h02, 8'h00},
                 {6'b000011, 6'b000001, 6'b000001, 6'b001001, 6'b000000}, 0);

    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    sel8 = 1'b0;
    wr16 = 1'b0; rd16 = 1'b0; wr8 = 1'b0; rd8 = 1'b0;
    dev_id = 7'h0; reg_addr = 16'h0; wr_data = 8'h0;
    Rx_DATA = 8'h0; Trans_Done = 1'b0; ack_o = 1'b0;
    Rst_p = 1'b1;
    #1;
    check("reset_outputs16", {cmd16, go16, tx16, rd_data16, rw_done16, ack_err16, busy16}, 0);
    check("reset_outputs8", {cmd8, go8, tx8, rd_data8, rw_done8, ack_err8, busy8}, 0);
    repeat (3) @(negedge Clk);
    Rst_p = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset in the middle of the third byte of a read.
    sel8 = 1'b0;
    dev_id = 7'h3C; reg_addr = 16'h300A; wr_data = 8'h00;
    set_req(0, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      wait_go(cyc);
      check($sformatf("rst_seq b%0d go", b), go_s, 1);
      if (b == 0) set_req(0, 1'b0, 1'b0);
      if (b < 2) begin
        repeat (2) @(negedge Clk);
        Trans_Done = 1'b1;
        @(negedge Clk);
        Trans_Done = 1'b0;
      end
    end
    check("rst_seq b2 cmd", cmd_s, 6'b001001);
    @(negedge Clk);
    Rst_p = 1'b1;
    #1;
    check("rst_mid_outputs", {cmd_s, go_s, tx_s, rw_done_s, ack_err_s, busy_s}, 0);
    check("rst_mid_rd_data", rd_data_s, 0);
    last_rd[0] = 8'h00;
    repeat (2) @(negedge Clk);
    Rst_p = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (rw_done_s || go_s || busy_s) seen = 1'b1;
    end
    check("rst_no_done", seen, 0);
    $display("[TB] txn rst: read aborted by reset");

    run_vec(vecs[7], 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
